// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback for one
// shared ALU, register file and unified memory port; counts retired instructions.
module multicycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       instruction_type,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef enum logic [3:0] {
    S_INIT     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EX_R     = 4'd3,
    S_EX_I     = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_WB_ALU   = 4'd8,
    S_WB_MEM   = 4'd9,
    S_BRANCH   = 4'd10,
    S_HALT     = 4'd11
  } state_e;

  state_e           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire_c;
  logic             taken_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Sticky illegal flag and retired-instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  // Next-state, retire and illegal-flag logic
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    retire_c  = 1'b0;
    unique case (state_q)
      S_INIT:  state_d = S_FETCH;
      S_FETCH: if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        unique case (opcode)
          OP_R:         state_d = S_EX_R;
          OP_I:         state_d = S_EX_I;
          OP_LD, OP_ST: state_d = S_MEM_ADDR;
          OP_BR: begin
            if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
              state_d = S_BRANCH;
            end else begin
              state_d   = S_HALT;
              illegal_d = 1'b1;
            end
          end
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EX_R:     state_d = S_WB_ALU;
      S_EX_I:     state_d = S_WB_ALU;
      S_MEM_ADDR: state_d = (opcode == OP_LD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) state_d = S_WB_MEM;
      S_MEM_WR: begin
        if (mem_ready) begin
          state_d  = S_FETCH;
          retire_c = 1'b1;
        end
      end
      S_WB_ALU: begin
        state_d  = S_FETCH;
        retire_c = 1'b1;
      end
      S_WB_MEM: begin
        state_d  = S_FETCH;
        retire_c = 1'b1;
      end
      S_BRANCH: begin
        state_d  = S_FETCH;
        retire_c = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_INIT;
    endcase
    retired_d = retire_c ? retired_q + CNT_W'(1) : retired_q;
  end

  assign taken_c = (funct3 == F3_BEQ) ? zero : !zero;

  // Moore output decode; ir/pc writes in FETCH and pc_write in BRANCH qualify within the cycle
  always_comb begin
    mem_req          = 1'b0;
    mem_we           = 1'b0;
    mem_addr_sel     = 1'b0;
    ir_write         = 1'b0;
    pc_write         = 1'b0;
    pc_src           = 1'b0;
    alu_src_a        = 2'b00;
    alu_src_b        = 2'b00;
    instruction_type = 2'b00;
    reg_write        = 1'b0;
    mem_to_reg       = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
      end
      S_EX_R: begin
        alu_src_a        = 2'b10;
        instruction_type = 2'b10;
      end
      S_EX_I: begin
        alu_src_a        = 2'b10;
        alu_src_b        = 2'b10;
        instruction_type = 2'b11;
      end
      S_MEM_ADDR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
      end
      S_MEM_WR: begin
        mem_req      = 1'b1;
        mem_we       = 1'b1;
        mem_addr_sel = 1'b1;
      end
      S_WB_ALU: reg_write = 1'b1;
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a        = 2'b10;
        instruction_type = 2'b01;
        pc_src           = 1'b1;
        pc_write         = taken_c;
      end
      default: ;
    endcase
  end

  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed tables, hand sequences and a
// randomized instruction stream checked against an instruction-level schedule model.
module tb_multicycle_ctrl;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  typedef struct {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        zero;
    logic        mem_ready;
    logic [14:0] exp;
    string       name;
  } step_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        zero;
  logic        mem_ready;

  logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src;
  logic [1:0]  alu_src_a, alu_src_b, instruction_type;
  logic        reg_write, mem_to_reg, illegal;
  logic [31:0] retired;

  logic        mem_req4, mem_we4, mem_addr_sel4, ir_write4, pc_write4, pc_src4;
  logic [1:0]  alu_src_a4, alu_src_b4, instruction_type4;
  logic        reg_write4, mem_to_reg4, illegal4;
  logic [3:0]  retired4;

  int    checks = 0;
  int    failures = 0;
  int    exp_retired = 0;
  int    addr_sel_cycles = 0;
  step_t sched[$];
  step_t add_tbl[6];

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .instruction_type(instruction_type), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .illegal(illegal), .retired(retired)
  );

  multicycle_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req4), .mem_we(mem_we4), .mem_addr_sel(mem_addr_sel4),
    .ir_write(ir_write4), .pc_write(pc_write4), .pc_src(pc_src4), .alu_src_a(alu_src_a4),
    .alu_src_b(alu_src_b4), .instruction_type(instruction_type4), .reg_write(reg_write4),
    .mem_to_reg(mem_to_reg4), .illegal(illegal4), .retired(retired4)
  );

  // Control word: req we asel irw pcw psrc a[2] b[2] it[2] rw m2r ill
  function automatic logic [14:0] w(input logic req, input logic we, input logic asel,
                                    input logic irw, input logic pcw, input logic psrc,
                                    input logic [1:0] a, input logic [1:0] b,
                                    input logic [1:0] it, input logic rw, input logic m2r,
                                    input logic ill);
    return {req, we, asel, irw, pcw, psrc, a, b, it, rw, m2r, ill};
  endfunction

  function automatic logic [14:0] dut_word();
    return {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, alu_src_a,
            alu_src_b, instruction_type, reg_write, mem_to_reg, illegal};
  endfunction

  function automatic step_t mk(input logic [6:0] op, input logic [2:0] f3, input logic z,
                               input logic rdy, input logic [14:0] e, input string n);
    step_t s;
    s.opcode = op; s.funct3 = f3; s.zero = z; s.mem_ready = rdy; s.exp = e; s.name = n;
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Expected per-cycle schedule of one instruction, from the architectural rules
  function automatic void expand(input logic [6:0] op, input logic [2:0] f3, input int wf,
                                 input int wm, input logic z);
    logic rz;
    for (int i = 0; i < wf; i++)
      sched.push_back(mk(op, f3, 1'($urandom), 1'b0, w(1,0,0,0,0,0,2'b00,2'b01,2'b00,0,0,0), "fetch_wait"));
    sched.push_back(mk(op, f3, 1'($urandom), 1'b1, w(1,0,0,1,1,0,2'b00,2'b01,2'b00,0,0,0), "fetch_done"));
    sched.push_back(mk(op, f3, 1'($urandom), 1'($urandom), w(0,0,0,0,0,0,2'b01,2'b10,2'b00,0,0,0), "decode"));
    rz = 1'($urandom);
    case (op)
      OP_R: begin
        sched.push_back(mk(op, f3, rz, 1'($urandom), w(0,0,0,0,0,0,2'b10,2'b00,2'b10,0,0,0), "ex_r"));
        sched.push_back(mk(op, f3, rz, 1'($urandom), w(0,0,0,0,0,0,2'b00,2'b00,2'b00,1,0,0), "wb_alu"));
      end
      OP_I: begin
        sched.push_back(mk(op, f3, rz, 1'($urandom), w(0,0,0,0,0,0,2'b10,2'b10,2'b11,0,0,0), "ex_i"));
        sched.push_back(mk(op, f3, rz, 1'($urandom), w(0,0,0,0,0,0,2'b00,2'b00,2'b00,1,0,0), "wb_alu"));
      end
      OP_LD, OP_ST: begin
        logic st;
        st = (op == OP_ST);
        sched.push_back(mk(op, f3, rz, 1'($urandom), w(0,0,0,0,0,0,2'b10,2'b10,2'b00,0,0,0), "mem_addr"));
        for (int i = 0; i < wm; i++)
          sched.push_back(mk(op, f3, rz, 1'b0, w(1,st,1,0,0,0,2'b00,2'b00,2'b00,0,0,0), "mem_wait"));
        sched.push_back(mk(op, f3, rz, 1'b1, w(1,st,1,0,0,0,2'b00,2'b00,2'b00,0,0,0), "mem_done"));
        if (!st)
          sched.push_back(mk(op, f3, rz, 1'($urandom), w(0,0,0,0,0,0,2'b00,2'b00,2'b00,1,1,0), "wb_mem"));
      end
      default: begin
        logic tk;
        tk = (f3 == 3'b000) ? z : !z;
        sched.push_back(mk(op, f3, z, 1'($urandom), w(0,0,0,0,tk,1,2'b10,2'b00,2'b01,0,0,0), "branch"));
      end
    endcase
  endfunction

  // Entered and left at posedge+1; outputs sampled at the negedge
  task automatic run_sched();
    step_t s;
    while (sched.size() > 0) begin
      s = sched.pop_front();
      opcode = s.opcode; funct3 = s.funct3; zero = s.zero; mem_ready = s.mem_ready;
      @(negedge clk);
      if (mem_req && mem_addr_sel) addr_sel_cycles++;
      check(s.name, 32'(dut_word()), 32'(s.exp));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input int wf,
                           input int wm, input logic z);
    expand(op, f3, wf, wm, z);
    run_sched();
    exp_retired++;
    check("retired", retired, 32'(exp_retired));
    check("retired_w4", 32'(retired4), 32'(exp_retired % 16));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_word", 32'(dut_word()), 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_retired_w4", 32'(retired4), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_retired = 0;
    sched.push_back(mk(OP_R, 3'b000, 1'b0, 1'b1, 15'd0, "init"));
    run_sched();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] add_insn;
    logic [14:0] fetch_wait_w;
    add_insn = 32'h002081B3;
    fetch_wait_w = w(1,0,0,0,0,0,2'b00,2'b01,2'b00,0,0,0);

    add_tbl[0] = mk(add_insn[6:0], add_insn[14:12], 1'b0, 1'b1, 15'd0, "add_init");
    add_tbl[1] = mk(add_insn[6:0], add_insn[14:12], 1'b0, 1'b1, w(1,0,0,1,1,0,2'b00,2'b01,2'b00,0,0,0), "add_fetch");
    add_tbl[2] = mk(add_insn[6:0], add_insn[14:12], 1'b0, 1'b1, w(0,0,0,0,0,0,2'b01,2'b10,2'b00,0,0,0), "add_decode");
    add_tbl[3] = mk(add_insn[6:0], add_insn[14:12], 1'b0, 1'b1, w(0,0,0,0,0,0,2'b10,2'b00,2'b10,0,0,0), "add_ex_r");
    add_tbl[4] = mk(add_insn[6:0], add_insn[14:12], 1'b0, 1'b1, w(0,0,0,0,0,0,2'b00,2'b00,2'b00,1,0,0), "add_wb_alu");
    add_tbl[5] = mk(add_insn[6:0], add_insn[14:12], 1'b0, 1'b0, fetch_wait_w, "add_fetch_next");

    rst_n = 1'b0; opcode = '0; funct3 = '0; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_word", 32'(dut_word()), 32'd0);
    check("rst_retired", retired, 32'd0);
    rst_n = 1'b1;

    // ADD directly after reset release, mem_ready tied high
    for (int i = 0; i < 6; i++) sched.push_back(add_tbl[i]);
    run_sched();
    exp_retired = 1;
    check("add_retired", retired, 32'd1);

    // LW with three wait states in the read
    addr_sel_cycles = 0;
    run_instr(OP_LD, 3'b010, 0, 3, 1'b0);
    check("lw_addr_sel_cycles", 32'(addr_sel_cycles), 32'd4);

    // BEQ taken and BNE not taken, both with zero = 1
    run_instr(OP_BR, 3'b000, 0, 0, 1'b1);
    run_instr(OP_BR, 3'b001, 0, 0, 1'b1);
    run_instr(OP_BR, 3'b001, 1, 0, 1'b0);

    // Reset in the middle of a store wait
    expand(OP_ST, 3'b010, 0, 2, 1'b0);
    void'(sched.pop_back());
    run_sched();
    mem_ready = 1'b0;
    #2;
    check("sw_wait_req", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_mem_req", 32'(mem_req), 32'd0);
    check("async_mem_we", 32'(mem_we), 32'd0);
    check("async_retired", retired, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_retired = 0;
    sched.push_back(mk(OP_ST, 3'b010, 1'b0, 1'b0, 15'd0, "post_rst_init"));
    sched.push_back(mk(OP_ST, 3'b010, 1'b0, 1'b0, fetch_wait_w, "post_rst_fetch"));
    run_sched();

    // 17 ADDIs: the 4-bit counter wraps to 1
    for (int i = 0; i < 17; i++) run_instr(OP_I, 3'b000, 0, 0, 1'b0);
    check("wrap_retired", retired, 32'd17);
    check("wrap_retired_w4", 32'(retired4), 32'd1);

    // Randomized instruction stream with random wait states
    do_reset();
    for (int n = 0; n < 150; n++) begin
      int unsigned k;
      k = $urandom_range(0, 5);
      case (k)
        0: run_instr(OP_R,  3'($urandom), $urandom_range(0, 3), 0, 1'b0);
        1: run_instr(OP_I,  3'($urandom), $urandom_range(0, 3), 0, 1'b0);
        2: run_instr(OP_LD, 3'b010, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
        3: run_instr(OP_ST, 3'b010, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
        4: run_instr(OP_BR, 3'b000, $urandom_range(0, 3), 0, 1'($urandom));
        default: run_instr(OP_BR, 3'b001, $urandom_range(0, 3), 0, 1'($urandom));
      endcase
    end

    // Illegal opcode: halt forever with no memory traffic until reset
    expand(7'b1111111, 3'b000, 0, 0, 1'b0);
    while (sched.size() > 2) void'(sched.pop_back());
    for (int i = 0; i < 20; i++)
      sched.push_back(mk(7'b1111111, 3'($urandom), 1'($urandom), 1'($urandom),
                         w(0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,1), "halt"));
    run_sched();
    check("halt_retired", retired, 32'(exp_retired));
    do_reset();
    check("illegal_cleared", 32'(illegal), 32'd0);
    sched.push_back(mk(OP_R, 3'b000, 1'b0, 1'b0, fetch_wait_w, "restart_fetch"));
    run_sched();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
